// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types, constants and helpers for the Simon game controller
//
// Contents:
//   state_t      : controller FSM states
//   LFSR_POLY    : Galois feedback mask for the 16-bit sequence LFSRs
//   ch_onehot()  : channel index -> 8-bit one-hot (caller slices to NUM_CH)

package simon_pkg;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAUSE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_PLAY_GAP = 3'd3,
        ST_REC      = 3'd4,
        ST_REC_WAIT = 3'd5,
        ST_FAIL     = 3'd6,
        ST_WIN      = 3'd7
    } state_t;

    // Sized for the largest supported channel count (8); narrower
    // configurations compare against the zero-extended switch vector.
    function automatic logic [7:0] ch_onehot(input logic [2:0] ch);
        return 8'b0000_0001 << ch;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// rtl/simon_lfsr.sv - 16-bit Galois LFSR with synchronous load and advance enable
//
// Ports:
//   clk      : clock
//   rst      : synchronous reset, active-low; state returns to RST_VAL
//   i_load   : load i_seed into the state (priority over i_en)
//   i_en     : advance the state by one Galois shift
//   i_seed   : value taken on i_load
//   o_state  : low OUT_W bits of the current state

module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [15:0] RST_VAL = 16'hACE1,
    parameter int          OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [15:0]      i_seed,
    output logic [OUT_W-1:0] o_state
);

    logic [15:0] r_state;
    logic [15:0] w_next;

    // Right-shifting Galois form: the bit shifted out selects the feedback mask.
    // A nonzero state never maps to zero, so a nonzero seed keeps it alive.
    assign w_next = {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_POLY : 16'h0000);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RST_VAL;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state[OUT_W-1:0];

endmodule

// File: rtl/simon_game_ctrl.sv
// rtl/simon_game_ctrl.sv - parametrised Simon game controller with internal timers and LFSRs
//
// Ports:
//   clk          : clock
//   rst          : synchronous reset, active-low
//   start        : one-cycle pulse; starts a game from IDLE, FAIL or WIN
//   sw           : debounced switch levels, one per channel
//   light        : light drive, one per channel
//   simons_turn  : 1 while the controller owns play (low in REC/REC_WAIT)
//   fini         : 1 in FAIL
//   win          : 1 in WIN
//   score        : current round length

module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          MAX_LEN    = 16,
    parameter int          SHOW_CYC   = 50,
    parameter int          MIN_SHOW   = 10,
    parameter int          SPEED_STEP = 2,
    parameter int          GAP_CYC    = 20,
    parameter int          USER_TO    = 500,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_CH-1:0]                sw,
    output logic [NUM_CH-1:0]                light,
    output logic                             simons_turn,
    output logic                             fini,
    output logic                             win,
    output logic [$clog2(MAX_LEN+1)-1:0]     score
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int SC_W   = $clog2(MAX_LEN + 1);
    localparam int TM_MX1 = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int TM_MAX = (TM_MX1 > USER_TO) ? TM_MX1 : USER_TO;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    // Timers count from 0; the "last" value is the final cycle spent in a state.
    localparam logic [TM_W-1:0] GAP_LAST  = TM_W'(GAP_CYC - 1);
    localparam logic [TM_W-1:0] USER_LAST = TM_W'(USER_TO - 1);
    localparam logic [SC_W-1:0] SC_ONE    = SC_W'(1);
    localparam logic [SC_W-1:0] SC_MAX    = SC_W'(MAX_LEN);

    state_t            r_state;
    logic [TM_W-1:0]   r_timer;
    logic [SC_W-1:0]   r_step;
    logic [SC_W-1:0]   r_score;
    logic [15:0]       r_seed;

    state_t            w_state_nxt;
    logic [TM_W-1:0]   w_timer_nxt;
    logic [SC_W-1:0]   w_step_nxt;
    logic [SC_W-1:0]   w_score_nxt;
    logic              w_seed_cap;
    logic              w_game_load;
    logic              w_game_en;

    logic [15:0]       w_free;
    logic [CH_W-1:0]   w_game_ch;
    logic [7:0]        w_onehot8;
    logic [7:0]        w_sw8;
    logic              w_sw_match;
    logic              w_sw_any;
    logic              w_timeout;
    logic              w_last_step;
    logic [31:0]       w_dec;
    logic [31:0]       w_show;
    logic [TM_W-1:0]   w_show_last;

    // Free-running source of per-game seeds; sampled when a game starts.
    simon_lfsr #(
        .RST_VAL (SEED),
        .OUT_W   (16)
    ) u_free_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (1'b0),
        .i_en    (1'b1),
        .i_seed  (16'h0000),
        .o_state (w_free)
    );

    // Replays the same sequence every round by reloading from r_seed.
    simon_lfsr #(
        .RST_VAL (SEED),
        .OUT_W   (CH_W)
    ) u_game_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_game_load),
        .i_en    (w_game_en),
        .i_seed  (r_seed),
        .o_state (w_game_ch)
    );

    assign w_onehot8   = ch_onehot(3'(w_game_ch));
    assign w_sw8       = 8'(sw);
    assign w_sw_match  = (w_sw8 == w_onehot8);
    assign w_sw_any    = |sw;
    assign w_timeout   = (r_timer == USER_LAST);
    assign w_last_step = (r_step == r_score);

    // Show time shrinks by SPEED_STEP per completed round, floored at MIN_SHOW.
    // Comparing SHOW_CYC against dec+MIN_SHOW avoids an unsigned underflow.
    always_comb begin
        w_dec = (r_score == '0) ? 32'd0
                                : (32'(r_score) - 32'd1) * 32'(SPEED_STEP);
        if (32'(SHOW_CYC) > w_dec + 32'(MIN_SHOW)) begin
            w_show = 32'(SHOW_CYC) - w_dec;
        end else begin
            w_show = 32'(MIN_SHOW);
        end
        w_show_last = TM_W'(w_show - 32'd1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_step_nxt  = r_step;
        w_score_nxt = r_score;
        w_seed_cap  = 1'b0;
        w_game_load = 1'b0;
        w_game_en   = 1'b0;

        case (r_state)
            ST_IDLE, ST_FAIL, ST_WIN: begin
                if (start) begin
                    w_state_nxt = ST_PAUSE;
                    w_score_nxt = SC_ONE;
                    w_step_nxt  = '0;
                    w_timer_nxt = '0;
                    w_seed_cap  = 1'b1;
                end
            end

            ST_PAUSE: begin
                if (r_timer == GAP_LAST) begin
                    w_state_nxt = ST_PLAY;
                    w_timer_nxt = '0;
                    w_step_nxt  = SC_ONE;
                    w_game_load = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            ST_PLAY: begin
                if (r_timer == w_show_last) begin
                    w_state_nxt = ST_PLAY_GAP;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            ST_PLAY_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_timer_nxt = '0;
                    if (w_last_step) begin
                        // Whole round shown: rewind the sequence for the user.
                        w_state_nxt = ST_REC;
                        w_step_nxt  = SC_ONE;
                        w_game_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_PLAY;
                        w_step_nxt  = r_step + 1'b1;
                        w_game_en   = 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            ST_REC: begin
                w_timer_nxt = r_timer + 1'b1;
                if (w_timeout) begin
                    w_state_nxt = ST_FAIL;
                end else if (w_sw_match) begin
                    w_state_nxt = ST_REC_WAIT;
                end else if (w_sw_any) begin
                    w_state_nxt = ST_FAIL;
                end
            end

            ST_REC_WAIT: begin
                // Press and release share one timeout window.
                w_timer_nxt = r_timer + 1'b1;
                if (w_timeout) begin
                    w_state_nxt = ST_FAIL;
                end else if (!w_sw_any) begin
                    w_timer_nxt = '0;
                    if (w_last_step) begin
                        if (r_score == SC_MAX) begin
                            w_state_nxt = ST_WIN;
                        end else begin
                            w_state_nxt = ST_PAUSE;
                            w_score_nxt = r_score + 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_REC;
                        w_step_nxt  = r_step + 1'b1;
                        w_game_en   = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_step  <= '0;
            r_score <= '0;
            r_seed  <= SEED;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_step  <= w_step_nxt;
            r_score <= w_score_nxt;
            if (w_seed_cap) begin
                r_seed <= w_free;
            end
        end
    end

    always_comb begin
        light       = '0;
        simons_turn = 1'b1;
        fini        = 1'b0;
        win         = 1'b0;
        case (r_state)
            ST_IDLE:     light = '1;
            ST_PLAY:     light = w_onehot8[NUM_CH-1:0];
            ST_REC: begin
                light       = sw;
                simons_turn = 1'b0;
            end
            ST_REC_WAIT: begin
                light       = sw;
                simons_turn = 1'b0;
            end
            ST_FAIL:     fini = 1'b1;
            ST_WIN: begin
                light = '1;
                win   = 1'b1;
            end
            default:     light = '0;
        endcase
    end

    assign score = r_score;

endmodule
